// File: rtl/sync_fifo_rv.sv
// Circular-buffer FIFO with valid/ready on both ends, first-word-fall-through read side.
// Latency: a write into an empty FIFO is visible on rd_data one cycle later; pops advance the head on the edge.
// Backpressure: wr_ready drops when full; rd_valid drops when empty. All outputs come from registered state.
//
// Ports:
//   clk, reset_n          clock (rising edge) and synchronous active-low reset
//   fifo_clear            synchronous flush, same effect as reset
//   wr_valid/wr_ready/wr_data   producer handshake and payload
//   rd_valid/rd_ready/rd_data   consumer handshake and head entry (0 when empty)
//   count                 occupancy 0..DEPTH
//   fifo_full/fifo_empty/fifo_almost_full/fifo_almost_empty   status decoded from count
//   overflow/underflow    sticky error flags, cleared only by fifo_clear or reset
module sync_fifo_rv #(
    parameter int DEPTH         = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_clear,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [CW-1:0]         count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  push;
    logic                  pop;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full         = (count_q == CW'(DEPTH));
    assign fifo_empty        = (count_q == '0);
    assign fifo_almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign fifo_almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    assign wr_ready          = ~fifo_full;
    assign rd_valid          = ~fifo_empty;
    assign rd_data           = fifo_empty ? '0 : mem[rd_ptr];
    assign count             = count_q;
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;

    assign push = wr_valid & wr_ready;
    assign pop  = rd_ready & rd_valid;

    always_ff @(posedge clk) begin
        if (!reset_n || fifo_clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (wr_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
            // A read request on an empty FIFO is only an error if no write
            // lands the same cycle; otherwise the data simply arrives next cycle.
            if (rd_ready && fifo_empty && !push) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage is not reset: stale entries are hidden behind rd_valid.
    always_ff @(posedge clk) begin
        if (reset_n && !fifo_clear && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_rv.sv
module tb_sync_fifo_rv;

    logic        clk;
    logic        rst_n [2];
    logic        clr   [2];
    logic        wv    [2];
    logic        rr    [2];
    logic [31:0] wd    [2];

    logic        wr_ready_a, rd_valid_a, full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
    logic [31:0] rd_data_a;
    logic [4:0]  count_a;
    logic        wr_ready_b, rd_valid_b, full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
    logic [31:0] rd_data_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;

    logic [31:0] o_count, o_full, o_empty, o_afull, o_aempty, o_wr_ready;
    logic [31:0] o_rd_valid, o_rd_data, o_ovf, o_unf;

    sync_fifo_rv #(.DEPTH(16), .DATA_WIDTH(32), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut_a (
        .clk(clk), .reset_n(rst_n[0]), .fifo_clear(clr[0]),
        .wr_valid(wv[0]), .wr_data(wd[0]), .wr_ready(wr_ready_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_ready(rr[0]),
        .count(count_a), .fifo_full(full_a), .fifo_empty(empty_a),
        .fifo_almost_full(afull_a), .fifo_almost_empty(aempty_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo_rv #(.DEPTH(5), .DATA_WIDTH(32), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .fifo_clear(clr[1]),
        .wr_valid(wv[1]), .wr_data(wd[1]), .wr_ready(wr_ready_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_ready(rr[1]),
        .count(count_b), .fifo_full(full_b), .fifo_empty(empty_b),
        .fifo_almost_full(afull_b), .fifo_almost_empty(aempty_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel == 0) begin
            o_count    = 32'(count_a);
            o_full     = 32'(full_a);
            o_empty    = 32'(empty_a);
            o_afull    = 32'(afull_a);
            o_aempty   = 32'(aempty_a);
            o_wr_ready = 32'(wr_ready_a);
            o_rd_valid = 32'(rd_valid_a);
            o_rd_data  = rd_data_a;
            o_ovf      = 32'(ovf_a);
            o_unf      = 32'(unf_a);
        end else begin
            o_count    = 32'(count_b);
            o_full     = 32'(full_b);
            o_empty    = 32'(empty_b);
            o_afull    = 32'(afull_b);
            o_aempty   = 32'(aempty_b);
            o_wr_ready = 32'(wr_ready_b);
            o_rd_valid = 32'(rd_valid_b);
            o_rd_data  = rd_data_b;
            o_ovf      = 32'(ovf_b);
            o_unf      = 32'(unf_b);
        end
    end

    function automatic int depth_of(input int s);
        return (s == 0) ? 16 : 5;
    endfunction
    function automatic int af_of(input int s);
        return (s == 0) ? 14 : 4;
    endfunction
    function automatic int ae_of(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (dut %0d) got=%0h exp=%0h", tag, sel, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge, outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        sel      = s;
        rst_n[s] = 1'b0;
        clr[s]   = 1'b0;
        wv[s]    = 1'b0;
        rr[s]    = 1'b0;
        wd[s]    = '0;
        step();
        rst_n[s] = 1'b1;
        check("rst_count",    o_count,    0);
        check("rst_empty",    o_empty,    1);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_rd_data",  o_rd_data,  0);
        check("rst_full",     o_full,     0);
        check("rst_wr_ready", o_wr_ready, 1);
        check("rst_aempty",   o_aempty,   1);
        check("rst_afull",    o_afull,    0);
        check("rst_ovf",      o_ovf,      0);
        check("rst_unf",      o_unf,      0);
    endtask

    // Reset, write 0..DEPTH-1, then one extra write into the full FIFO.
    task automatic fill(input int s);
        int d;
        d = depth_of(s);
        do_reset(s);
        for (int i = 0; i < d; i++) begin
            wv[s] = 1'b1;
            wd[s] = i;
            step();
            check("fill_count",  o_count,  i + 1);
            check("fill_afull",  o_afull,  32'((i + 1) >= af_of(s)));
            check("fill_aempty", o_aempty, 32'((i + 1) <= ae_of(s)));
        end
        check("full_flag",     o_full,     1);
        check("full_wr_ready", o_wr_ready, 0);
        check("full_ovf_pre",  o_ovf,      0);
        wd[s] = 32'h99;
        step();
        wv[s] = 1'b0;
        check("ovf_set",       o_ovf,   1);
        check("ovf_count",     o_count, d);
        check("ovf_head",      o_rd_data, 0);
        step();
        check("ovf_sticky",    o_ovf,   1);
    endtask

    task automatic drain(input int s);
        int d;
        d = depth_of(s);
        sel   = s;
        rr[s] = 1'b1;
        for (int i = 0; i < d; i++) begin
            check("pop_valid", o_rd_valid, 1);
            check("pop_data",  o_rd_data,  i);
            step();
        end
        check("drain_empty", o_empty,   1);
        check("drain_data0", o_rd_data, 0);
        check("drain_unf0",  o_unf,     0);
        step();
        rr[s] = 1'b0;
        check("unf_set",     o_unf,   1);
        check("unf_count",   o_count, 0);
    endtask

    task automatic stream(input int s);
        int d, n;
        d = depth_of(s);
        n = (d > 5) ? 5 : 3;
        do_reset(s);
        for (int i = 0; i < n; i++) begin
            wv[s] = 1'b1;
            wd[s] = i;
            step();
        end
        rr[s] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wd[s] = n + k;
            check("stream_data", o_rd_data, k);
            step();
            check("stream_count", o_count, n);
        end
        wv[s] = 1'b0;
        rr[s] = 1'b0;
        if (s == 0) begin
            check("wrap_rd_ptr", 32'(dut_a.rd_ptr), 40 % d);
            check("wrap_wr_ptr", 32'(dut_a.wr_ptr), (n + 40) % d);
        end else begin
            check("wrap_rd_ptr", 32'(dut_b.rd_ptr), 40 % d);
            check("wrap_wr_ptr", 32'(dut_b.wr_ptr), (n + 40) % d);
        end
        check("stream_unf", o_unf, 0);
        check("stream_ovf", o_ovf, 0);
    endtask

    task automatic pop_n(input int s, input int n);
        rr[s] = 1'b1;
        for (int i = 0; i < n; i++) step();
        rr[s] = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0;
            clr[s]   = 1'b0;
            wv[s]    = 1'b0;
            rr[s]    = 1'b0;
            wd[s]    = '0;
        end
        step();
        step();

        // 1: back-to-back pushes, head visible one cycle after the first
        do_reset(0);
        wv[0] = 1'b1;
        wd[0] = 32'h11;
        step();
        check("s1_valid", o_rd_valid, 1);
        check("s1_head",  o_rd_data,  32'h11);
        wd[0] = 32'h22;
        step();
        wd[0] = 32'h33;
        step();
        wv[0] = 1'b0;
        check("s1_count", o_count,   3);
        check("s1_head3", o_rd_data, 32'h11);

        // 2-4 on both depths
        for (int s = 0; s < 2; s++) begin
            fill(s);
            drain(s);
            stream(s);
        end

        // 5: push into empty with rd_ready high
        do_reset(0);
        wv[0] = 1'b1;
        wd[0] = 32'hAB;
        rr[0] = 1'b1;
        check("s5_valid_pre", o_rd_valid, 0);
        step();
        wv[0] = 1'b0;
        rr[0] = 1'b0;
        check("s5_valid", o_rd_valid, 1);
        check("s5_data",  o_rd_data,  32'hAB);
        check("s5_count", o_count,    1);
        check("s5_unf",   o_unf,      0);

        // 6: clear with a concurrent push, then the same via reset
        fill(0);
        pop_n(0, 9);
        check("s6_count7", o_count, 7);
        check("s6_ovf",    o_ovf,   1);
        clr[0] = 1'b1;
        wv[0]  = 1'b1;
        wd[0]  = 32'h5A;
        step();
        clr[0] = 1'b0;
        wv[0]  = 1'b0;
        check("clr_count", o_count,    0);
        check("clr_empty", o_empty,    1);
        check("clr_ovf",   o_ovf,      0);
        check("clr_valid", o_rd_valid, 0);
        check("clr_data",  o_rd_data,  0);

        fill(0);
        pop_n(0, 9);
        check("s6r_count7", o_count, 7);
        rst_n[0] = 1'b0;
        wv[0]    = 1'b1;
        wd[0]    = 32'h5A;
        step();
        rst_n[0] = 1'b1;
        wv[0]    = 1'b0;
        check("rstm_count", o_count,    0);
        check("rstm_empty", o_empty,    1);
        check("rstm_ovf",   o_ovf,      0);
        check("rstm_valid", o_rd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
